inc_serial: RTL and testbench



---
 rtl/inc_serial_if.sv | 13 +
 rtl/inc_serial.sv | 82 ++++++++
 tb/tb_inc_serial.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/inc_serial_if.sv
// Handshake and data bundle for the bit-serial incrementer.
interface inc_serial_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] A;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C;
    logic             carry;
    logic             zero;

    modport master (output start, A, input busy, done, C, carry, zero);
    modport slave  (input start, A, output busy, done, C, carry, zero);
endinterface

// File: rtl/inc_serial.sv
// Bit-serial C = A + 1, one bit per clock, stopping as soon as the carry dies.
module inc_serial #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    inc_serial_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] w, w_nxt, w_upd;
    logic             cy, cy_nxt, cy_upd;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] c_q, c_nxt;
    logic             carry_q, carry_nxt;
    logic             zero_q, zero_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            w       <= '0;
            cy      <= 1'b0;
            idx     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            w       <= w_nxt;
            cy      <= cy_nxt;
            idx     <= idx_nxt;
            c_q     <= c_nxt;
            carry_q <= carry_nxt;
            zero_q  <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        w_nxt     = w;
        cy_nxt    = cy;
        idx_nxt   = idx;
        c_nxt     = c_q;
        carry_nxt = carry_q;
        zero_nxt  = zero_q;
        // Half-adder on the current bit; upper bits already hold A.
        w_upd      = w;
        w_upd[idx] = w[idx] ^ cy;
        cy_upd     = w[idx] & cy;
        case (state)
            IDLE: if (bus.start) begin
                w_nxt     = bus.A;
                cy_nxt    = 1'b1;
                idx_nxt   = '0;
                state_nxt = RUN;
            end
            RUN: begin
                w_nxt  = w_upd;
                cy_nxt = cy_upd;
                if (!cy_upd || idx == IW'(WIDTH - 1)) begin
                    c_nxt     = w_upd;
                    carry_nxt = cy_upd;
                    zero_nxt  = (w_upd == '0);
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.C     = c_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_inc_serial.sv
// Randomized and directed bench for inc_serial at WIDTH=8 and WIDTH=4 against a cycle-level reference.
module tb_inc_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inc_serial_if #(.WIDTH(8)) if8 ();
    inc_serial_if #(.WIDTH(4)) if4 ();

    inc_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    inc_serial #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: per DUT, edges since the accepted start (-1 when idle).
    int         age   [2];
    int         nn    [2];
    logic [7:0] res   [2];
    logic       rcy   [2];
    logic [7:0] cur_c [2];
    logic       cur_cy[2];
    logic       cur_z [2];
    logic       armed [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            age[d] = -1; nn[d] = 1; res[d] = '0; rcy[d] = 1'b0;
            cur_c[d] = '0; cur_cy[d] = 1'b0; cur_z[d] = 1'b0; armed[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic       ob, od, ocy, oz, st;
            logic [7:0] oc, aa, mask;
            int         w, k;
            if (d == 0) begin
                w = 8; ob = if8.busy; od = if8.done; oc = if8.C; ocy = if8.carry; oz = if8.zero;
                st = if8.start; aa = if8.A;
            end else begin
                w = 4; ob = if4.busy; od = if4.done; oc = {4'b0, if4.C}; ocy = if4.carry; oz = if4.zero;
                st = if4.start; aa = {4'b0, if4.A};
            end
            mask = 8'((1 << w) - 1);
            if (armed[d]) begin
                chk($sformatf("busy_w%0d", w),  32'(ob),  32'(age[d] >= 0));
                chk($sformatf("done_w%0d", w),  32'(od),  32'(age[d] == nn[d]));
                chk($sformatf("C_w%0d", w),     32'(oc),  32'(cur_c[d]));
                chk($sformatf("carry_w%0d", w), 32'(ocy), 32'(cur_cy[d]));
                chk($sformatf("zero_w%0d", w),  32'(oz),  32'(cur_z[d]));
            end
            if (rst) begin
                age[d] = -1; cur_c[d] = '0; cur_cy[d] = 1'b0; cur_z[d] = 1'b0; armed[d] = 1'b1;
            end else if (age[d] >= 0) begin
                if (age[d] == nn[d]) age[d] = -1;
                else begin
                    age[d]++;
                    if (age[d] == nn[d]) begin
                        cur_c[d] = res[d]; cur_cy[d] = rcy[d]; cur_z[d] = (res[d] == 8'h00);
                    end
                end
            end else if (st === 1'b1) begin
                k = 0;
                while (k < w && aa[k]) k++;
                nn[d]  = (k + 1 < w) ? k + 1 : w;
                res[d] = (aa + 8'd1) & mask;
                rcy[d] = (aa == mask);
                age[d] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((if8.busy || if4.busy) && t < 40) begin tick(); t++; end
        if (t >= 40) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic go(input logic [7:0] a8, input logic [3:0] a4);
        wait_idle();
        if8.start = 1'b1; if8.A = a8;
        if4.start = 1'b1; if4.A = a4;
        tick();
        if8.start = 1'b0; if8.A = 8'($urandom);
        if4.start = 1'b0; if4.A = 4'($urandom);
    endtask

    initial begin
        logic [7:0] dir [4];
        dir[0] = 8'h0A; dir[1] = 8'h07; dir[2] = 8'hFF; dir[3] = 8'h7F;
        if8.start = 1'b0; if8.A = '0;
        if4.start = 1'b0; if4.A = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        foreach (dir[i]) go(dir[i], dir[i][3:0]);
        wait_idle();

        // Reset in the middle of a long ripple, then start right away.
        go(8'h7F, 4'h7);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        go(8'h03, 4'h3);
        wait_idle();

        // start held high while A changes every cycle.
        if8.start = 1'b1; if4.start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if8.A = 8'($urandom); if4.A = 4'($urandom);
            tick();
        end
        if8.start = 1'b0; if4.start = 1'b0;
        wait_idle();

        for (int i = 0; i < 256; i++) go(8'(i), 4'(i));
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            go(8'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
